// File: rtl/img_pkg.sv
// Shared constants and the in-flight read tag for the image ROM arbiter.
// Pure declarations: no logic, no latency, no flow control.
package img_pkg;

    localparam int COLOR_W = 12;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int IMG_W   = 250;
    localparam int IMG_H   = 100;
    localparam int MAX_REQ = 8;

    localparam logic [COLOR_W-1:0] OOR_COLOR = 12'h000;

    // id is sized for the largest supported requester count; unused high bits stay 0
    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] id;
        logic               oor;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer updated on grant.
// Zero latency; never stalls, requesters simply hold req until granted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;

    // search starts one past the last winner and wraps
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            sel = PW'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                ptr_d    = sel;
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/img_rom_arbiter.sv
// Shares one sync image ROM among N_REQ requesters; grant in cycle T returns tagged pixel in T+ROM_LAT+2.
// One grant per cycle, fully pipelined; requesters hold req until gnt, the return path never stalls.
module img_rom_arbiter
    import img_pkg::*;
#(
    parameter int                   N_REQ     = 4,
    parameter int                   IMG_W     = img_pkg::IMG_W,
    parameter int                   IMG_H     = img_pkg::IMG_H,
    parameter int                   ADDR_W    = 16,
    parameter int                   ROM_LAT   = 1,
    parameter logic [COLOR_W-1:0]   OOR_COLOR = img_pkg::OOR_COLOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   x_in,
    input  logic [N_REQ*Y_W-1:0]   y_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rvalid,
    output logic [COLOR_W-1:0]     rdata,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [COLOR_W-1:0]     rom_dout
);

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic               oor_d;
    logic [ADDR_W-1:0]  addr_d;
    tag_t               tag_d;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic [N_REQ-1:0]   rvalid_q;
    logic [COLOR_W-1:0] rdata_q;
    tag_t               tag_q [ROM_LAT+1];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_x = x_in[i*X_W +: X_W];
                sel_y = y_in[i*Y_W +: Y_W];
            end
        end
        // out-of-range coordinates must never alias into a neighbouring row
        oor_d       = (int'(sel_x) >= IMG_W) || (int'(sel_y) >= IMG_H);
        addr_d      = ADDR_W'(IMG_W) * ADDR_W'(sel_y) + ADDR_W'(sel_x);
        tag_d.valid = |gnt;
        tag_d.id    = MAX_REQ'(gnt);
        tag_d.oor   = oor_d;
    end

    // tag pipeline is one stage longer than the ROM so the data is registered on return
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (tag_d.valid) begin
                rom_addr_q <= oor_d ? '0 : addr_d;
            end
            tag_q[0] <= tag_d;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rvalid_q <= tag_q[ROM_LAT].valid ? tag_q[ROM_LAT].id[N_REQ-1:0] : '0;
            if (tag_q[ROM_LAT].valid) begin
                rdata_q <= tag_q[ROM_LAT].oor ? OOR_COLOR : rom_dout;
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Directed bench for img_rom_arbiter: cycle table plus a latency sequence, ROM_LAT=1 and ROM_LAT=2 instances.
module tb_img_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [39:0] x_in = '0;
    logic [35:0] y_in = '0;

    logic [3:0]  gnt1, gnt2, rv1, rv2;
    logic [11:0] rd1, rd2, dout1, dout2, dout2_s;
    logic [15:0] a1, a2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [15:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    // ROM models: 1-cycle and 2-cycle synchronous reads
    always @(posedge clk) begin
        dout1   <= rom_f(a1);
        dout2_s <= rom_f(a2);
        dout2   <= dout2_s;
    end

    img_rom_arbiter #(.ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
        .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .rom_addr(a1), .rom_dout(dout1)
    );

    img_rom_arbiter #(.ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
        .gnt(gnt2), .rvalid(rv2), .rdata(rd2), .rom_addr(a2), .rom_dout(dout2)
    );

    localparam logic [5:0] G = 6'd1, V = 6'd2, D = 6'd4, A = 6'd8, V2 = 6'd16, D2 = 6'd32;

    typedef struct {
        logic [5:0]  m;
        logic        rst;
        logic [3:0]  req;
        logic [39:0] x;
        logic [35:0] y;
        logic [3:0]  g;
        logic [3:0]  v;
        logic [11:0] d;
        logic [15:0] a;
        logic [3:0]  v2;
        logic [11:0] d2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [39:0] px(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [35:0] py(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic add(input logic [5:0] m, input logic r, input logic [3:0] rq,
                       input logic [39:0] x, input logic [35:0] y, input logic [3:0] g,
                       input logic [3:0] v, input logic [11:0] d, input logic [15:0] a,
                       input logic [3:0] v2, input logic [11:0] d2);
        vec_t e;
        e.m = m; e.rst = r; e.req = rq; e.x = x; e.y = y; e.g = g;
        e.v = v; e.d = d; e.a = a; e.v2 = v2; e.d2 = d2;
        vecs.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [39:0] xc;
        logic [35:0] yc;
        logic [39:0] x0;
        logic [35:0] y0;
        int lat1, lat2;
        logic [11:0] dat1, dat2;
        logic [3:0]  id1, id2;

        x0 = px(0, 0, 0, 0);
        y0 = py(0, 0, 0, 0);
        // reset, single request, ROM_LAT=2 return
        add(G,              1, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V|D|A|V2,     1, 4'b0001, px(3,0,0,0), py(2,0,0,0), 4'b0000, 0, 0, 0, 0, 0);
        add(G|V|D|A|V2,     0, 4'b0001, px(3,0,0,0), py(2,0,0,0), 4'b0001, 0, 0, 0, 0, 0);
        add(G|V|A|V2,       0, 4'b0000, x0, y0, 4'b0000, 0, 0, 503, 0, 0);
        add(G|V|V2,         0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V|D|A|V2,     0, 4'b0000, x0, y0, 4'b0000, 4'b0001, rom_f(503), 503, 0, 0);
        add(G|V|V2|D2,      1, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 4'b0001, rom_f(503));
        // contention 0,1,2,3 then in-order returns
        xc = px(0, 1, 2, 3);
        yc = py(1, 1, 1, 1);
        add(G|V|D|A|V2,     0, 4'b1111, xc, yc, 4'b0001, 0, 0, 0, 0, 0);
        add(G|V|A,          0, 4'b1110, xc, yc, 4'b0010, 0, 0, 250, 0, 0);
        add(G|V|A,          0, 4'b1100, xc, yc, 4'b0100, 0, 0, 251, 0, 0);
        add(G|V|D|A,        0, 4'b1000, xc, yc, 4'b1000, 4'b0001, rom_f(250), 252, 0, 0);
        add(G|V|D|A,        0, 4'b0000, x0, y0, 4'b0000, 4'b0010, rom_f(251), 253, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b0100, rom_f(252), 0, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b1000, rom_f(253), 0, 0, 0);
        // fairness after wrap: ptr becomes 2, then req 0101
        add(G|V,            0, 4'b0100, px(0,0,5,0), y0, 4'b0100, 0, 0, 0, 0, 0);
        add(G|V|A,          0, 4'b0101, px(7,0,8,0), y0, 4'b0001, 0, 0, 5, 0, 0);
        add(G|V|A,          0, 4'b0100, px(7,0,8,0), y0, 4'b0100, 0, 0, 7, 0, 0);
        add(G|V|D|A,        0, 4'b0000, x0, y0, 4'b0000, 4'b0100, rom_f(5), 8, 0, 0);
        // lone req[1] held five cycles at the last in-range pixel
        xc = px(0, 249, 0, 0);
        yc = py(0, 99, 0, 0);
        add(G|V|D,          0, 4'b0010, xc, yc, 4'b0010, 4'b0001, rom_f(7), 0, 0, 0);
        add(G|V|D|A,        0, 4'b0010, xc, yc, 4'b0010, 4'b0100, rom_f(8), 24999, 0, 0);
        add(G|V|A,          0, 4'b0010, xc, yc, 4'b0010, 0, 0, 24999, 0, 0);
        add(G|V|D|A,        0, 4'b0010, xc, yc, 4'b0010, 4'b0010, rom_f(24999), 24999, 0, 0);
        add(G|V|D,          0, 4'b0010, xc, yc, 4'b0010, 4'b0010, rom_f(24999), 0, 0, 0);
        // out-of-range coordinates
        add(G|V|D|A,        0, 4'b0001, px(250,0,0,0), y0, 4'b0001, 4'b0010, rom_f(24999), 24999, 0, 0);
        add(G|V|D|A,        0, 4'b0001, x0, py(100,0,0,0), 4'b0001, 4'b0010, rom_f(24999), 0, 0, 0);
        add(G|V|D|A,        0, 4'b1000, px(0,0,0,1023), py(0,0,0,511), 4'b1000, 4'b0010, rom_f(24999), 0, 0, 0);
        add(G|V|D|A,        0, 4'b0000, x0, y0, 4'b0000, 4'b0001, 12'h000, 0, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b0001, 12'h000, 0, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b1000, 12'h000, 0, 0, 0);
        add(G|V,            0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        // reset while a read is in flight
        add(G|V,            0, 4'b0001, px(3,0,0,0), py(2,0,0,0), 4'b0001, 0, 0, 0, 0, 0);
        add(G|V|A,          1, 4'b0001, px(3,0,0,0), py(2,0,0,0), 4'b0000, 0, 0, 503, 0, 0);
        add(G|V|D|A,        0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V,            0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V,            0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V,            0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);
        add(G|V,            0, 4'b1001, px(1,0,0,2), y0, 4'b0001, 0, 0, 0, 0, 0);
        add(G|V|A,          0, 4'b1000, px(1,0,0,2), y0, 4'b1000, 0, 0, 1, 0, 0);
        add(G|V|A,          0, 4'b0000, x0, y0, 4'b0000, 0, 0, 2, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b0001, rom_f(1), 0, 0, 0);
        add(G|V|D,          0, 4'b0000, x0, y0, 4'b0000, 4'b1000, rom_f(2), 0, 0, 0);
        add(G|V,            0, 4'b0000, x0, y0, 4'b0000, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            x_in = vecs[i].x;
            y_in = vecs[i].y;
            @(negedge clk);
            if (vecs[i].m[0]) chk($sformatf("row%0d_gnt", i), 32'(gnt1), 32'(vecs[i].g));
            if (vecs[i].m[1]) chk($sformatf("row%0d_rvalid", i), 32'(rv1), 32'(vecs[i].v));
            if (vecs[i].m[2]) chk($sformatf("row%0d_rdata", i), 32'(rd1), 32'(vecs[i].d));
            if (vecs[i].m[3]) chk($sformatf("row%0d_rom_addr", i), 32'(a1), 32'(vecs[i].a));
            if (vecs[i].m[4]) chk($sformatf("row%0d_rvalid_lat2", i), 32'(rv2), 32'(vecs[i].v2));
            if (vecs[i].m[5]) chk($sformatf("row%0d_rdata_lat2", i), 32'(rd2), 32'(vecs[i].d2));
            @(posedge clk);
            #1;
        end

        // latency sequence: grant in cycle 0, bounded wait for each return
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 4'b0100;
        x_in = px(0, 0, 10, 0);
        y_in = py(0, 0, 3, 0);
        @(negedge clk);
        chk("seq_gnt", 32'(gnt1), 32'(4'b0100));
        chk("seq_gnt_lat2", 32'(gnt2), 32'(4'b0100));
        @(posedge clk);
        #1;
        req  = '0;
        lat1 = 0; lat2 = 0;
        dat1 = '0; dat2 = '0; id1 = '0; id2 = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (lat1 == 0 && rv1 != 0) begin lat1 = n; dat1 = rd1; id1 = rv1; end
            if (lat2 == 0 && rv2 != 0) begin lat2 = n; dat2 = rd2; id2 = rv2; end
        end
        chk("seq_latency", 32'(lat1), 32'd3);
        chk("seq_latency_lat2", 32'(lat2), 32'd4);
        chk("seq_rdata", 32'(dat1), 32'(rom_f(16'd760)));
        chk("seq_rdata_lat2", 32'(dat2), 32'(rom_f(16'd760)));
        chk("seq_id", 32'(id1), 32'(4'b0100));
        chk("seq_id_lat2", 32'(id2), 32'(4'b0100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
